// File: rtl/gpio_pkg.sv
// Shared definitions for the APB GPIO port: register indices and the arm-counter sizing helper.
package gpio_pkg;

    localparam logic [2:0] REG_IN      = 3'd0;
    localparam logic [2:0] REG_OUT     = 3'd1;
    localparam logic [2:0] REG_OE      = 3'd2;
    localparam logic [2:0] REG_RISE_EN = 3'd3;
    localparam logic [2:0] REG_FALL_EN = 3'd4;
    localparam logic [2:0] REG_STATUS  = 3'd5;
    localparam logic [2:0] REG_IRQ_EN  = 3'd6;
    localparam int         REG_COUNT   = 7;

`ifdef GPIO_DEBOUNCE_EN
    localparam bit DEBOUNCE_ON = 1'b1;
`else
    localparam bit DEBOUNCE_ON = 1'b0;
`endif

    // The arm counter must hold stages+1, so it needs clog2(stages+2) bits.
    function automatic int arm_cnt_w(input int stages);
        return $clog2(stages + 2);
    endfunction

endpackage

// File: rtl/gpio_chan_sync.sv
// One GPIO input channel: synchroniser, optional debounce (GPIO_DEBOUNCE_EN), previous-sample flop
// and gated rise/fall pulses.
module gpio_chan_sync #(
    parameter int SYNC_STAGES = 2
`ifdef GPIO_DEBOUNCE_EN
    , parameter int DEBOUNCE_CYCLES = 4
`endif
) (
    input  logic clk,
    input  logic rst,
    input  logic pin,
    input  logic armed,
    input  logic rise_en,
    input  logic fall_en,
    output logic sync,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] chain;
    logic                   raw;
    logic                   prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) chain <= '0;
        else     chain <= {chain[SYNC_STAGES-2:0], pin};
    end

    assign raw = chain[SYNC_STAGES-1];

`ifdef GPIO_DEBOUNCE_EN
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [CNT_W-1:0] cnt;
    logic             stable;

    // Count consecutive cycles the raw value disagrees with the accepted one; any agreement restarts.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt    <= '0;
            stable <= 1'b0;
        end else if (raw == stable) begin
            cnt <= '0;
        end else if (cnt == CNT_LAST) begin
            stable <= raw;
            cnt    <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign sync = stable;
`else
    assign sync = raw;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) prev <= 1'b0;
        else     prev <= sync;
    end

    assign rise = armed & rise_en &  sync & ~prev;
    assign fall = armed & fall_en & ~sync &  prev;

endmodule

// File: rtl/apb_gpio_port.sv
// APB GPIO port: register file, APB decode, sticky W1C edge status and level IRQ.
// Optional input debounce is built when GPIO_DEBOUNCE_EN is defined.
module apb_gpio_port
    import gpio_pkg::*;
#(
    parameter int WIDTH           = 8,
    parameter int ADDR_W          = 5,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic              PSEL,
    input  logic [ADDR_W-1:0] PADDR,
    input  logic              PENABLE,
    input  logic              PWRITE,
    input  logic [WIDTH-1:0]  PWDATA,
    output logic [WIDTH-1:0]  PRDATA,
    output logic              PREADY,
    input  logic [WIDTH-1:0]  PIN_IN,
    output logic [WIDTH-1:0]  PIN_OUT,
    output logic [WIDTH-1:0]  PIN_OE,
    output logic              IRQ
);

    // Edges are ignored until the synchroniser (and debounce, if present) has flushed reset values.
    localparam int DB_EXTRA   = DEBOUNCE_ON ? DEBOUNCE_CYCLES : 0;
    localparam int ARM_CYCLES = SYNC_STAGES + 1 + DB_EXTRA;
    localparam int ARM_W      = arm_cnt_w(SYNC_STAGES + DB_EXTRA);
    localparam logic [ARM_W-1:0] ARM_DONE = ARM_W'(ARM_CYCLES);

    logic [WIDTH-1:0] out_r, oe_r, rise_en_r, fall_en_r, status_r, irq_en_r;
    logic [WIDTH-1:0] sync_v, rise_v, fall_v, w1c, rd_data;
    logic [ARM_W-1:0] arm_cnt;
    logic             armed;
    logic [2:0]       idx;
    logic             hit, wr, rd;

    // APB handshake: PSEL&~PENABLE is a side-effect-free setup phase; PSEL&PENABLE is the access phase,
    // which always completes in one cycle (PREADY tied high). Writes commit on that edge; reads are
    // combinational while it lasts.
    assign PREADY = 1'b1;
    assign idx    = PADDR[2:0];
    assign hit    = ((PADDR >> 3) == '0) && (int'(idx) < REG_COUNT);
    assign wr     = PSEL & PENABLE &  PWRITE & hit;
    assign rd     = PSEL & PENABLE & ~PWRITE & hit;

    for (genvar i = 0; i < WIDTH; i++) begin : g_chan
        gpio_chan_sync #(
            .SYNC_STAGES    (SYNC_STAGES)
`ifdef GPIO_DEBOUNCE_EN
            , .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
`endif
        ) u_chan (
            .clk     (PCLK),
            .rst     (PRESET),
            .pin     (PIN_IN[i]),
            .armed   (armed),
            .rise_en (rise_en_r[i]),
            .fall_en (fall_en_r[i]),
            .sync    (sync_v[i]),
            .rise    (rise_v[i]),
            .fall    (fall_v[i])
        );
    end

    assign armed = (arm_cnt == ARM_DONE);

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET)      arm_cnt <= '0;
        else if (!armed) arm_cnt <= arm_cnt + 1'b1;
    end

    assign w1c = (wr && idx == REG_STATUS) ? PWDATA : '0;

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            out_r     <= '0;
            oe_r      <= '0;
            rise_en_r <= '0;
            fall_en_r <= '0;
            status_r  <= '0;
            irq_en_r  <= '0;
            IRQ       <= 1'b0;
        end else begin
            if (wr) begin
                case (idx)
                    REG_OUT:     out_r     <= PWDATA;
                    REG_OE:      oe_r      <= PWDATA;
                    REG_RISE_EN: rise_en_r <= PWDATA;
                    REG_FALL_EN: fall_en_r <= PWDATA;
                    REG_IRQ_EN:  irq_en_r  <= PWDATA;
                    default:     ;
                endcase
            end
            // A new edge in the same cycle as its clear keeps the bit set.
            status_r <= (status_r & ~w1c) | rise_v | fall_v;
            IRQ      <= |(status_r & irq_en_r);
        end
    end

    always_comb begin
        rd_data = '0;
        case (idx)
            REG_IN:      rd_data = sync_v;
            REG_OUT:     rd_data = out_r;
            REG_OE:      rd_data = oe_r;
            REG_RISE_EN: rd_data = rise_en_r;
            REG_FALL_EN: rd_data = fall_en_r;
            REG_STATUS:  rd_data = status_r;
            REG_IRQ_EN:  rd_data = irq_en_r;
            default:     rd_data = '0;
        endcase
    end

    assign PRDATA  = (rd && !PRESET) ? rd_data : '0;
    assign PIN_OUT = out_r;
    assign PIN_OE  = oe_r;

endmodule

// File: doc/apb_gpio_port.md
Name: apb_gpio_port

Overview:
Parametrised APB slave GPIO port; successor to the fixed two-flop input register / output register pair behind the I2C-to-APB bridge.
- Provides WIDTH synchronised inputs with per-channel rising/falling edge capture.
- Provides a sticky write-1-to-clear edge status register and a maskable level interrupt.
- Provides a software-driven output register with per-bit output enable, so pins map directly onto uio_out/uio_oe.

Parameters:
WIDTH, 8, channel count and APB data width (1..32).
ADDR_W, 5, PADDR width; register index = PADDR[2:0], upper bits must be 0.
SYNC_STAGES, 2, input synchroniser depth (>=2).
DEBOUNCE_CYCLES, 4, stable-cycle count required when GPIO_DEBOUNCE_EN is defined (>=1).

Ports:
PCLK  in  1  single clock.
PRESET  in  1  asynchronous, active-high reset.
PSEL  in  1  APB select.
PADDR  in  ADDR_W  APB address.
PENABLE  in  1  APB access phase.
PWRITE  in  1  1 = write.
PWDATA  in  WIDTH  write data.
PRDATA  out  WIDTH  read data.
PREADY  out  1  always 1 (zero wait state).
PIN_IN  in  WIDTH  asynchronous pad inputs.
PIN_OUT  out  WIDTH  output data.
PIN_OE  out  WIDTH  output enables (1 = drive).
IRQ  out  1  level interrupt.

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- Reset state:
  - All registers, sync flops and prev-sample = 0.
  - PIN_OUT = 0, PIN_OE = 0, IRQ = 0, PRDATA = 0.
  - PREADY = 1.
- APB timing:
  - Write commits on the PCLK edge where PSEL & PENABLE & PWRITE.
  - PRDATA is combinational from the addressed register while PSEL & PENABLE & ~PWRITE; 0 otherwise.
  - Setup phase has no side effects.
- Register map (index):
  - 0 IN: read-only, synchronised inputs.
  - 1 OUT: read/write, drives PIN_OUT.
  - 2 OE: read/write, drives PIN_OE.
  - 3 RISE_EN: read/write.
  - 4 FALL_EN: read/write.
  - 5 STATUS: write-1-to-clear.
  - 6 IRQ_EN: read/write.
  - 7, or any access with nonzero upper PADDR bits: reads 0, writes ignored.
- Sync path:
  - PIN_IN feeds a SYNC_STAGES flop chain; the last stage is `sync`.
  - `prev` holds `sync` delayed by one cycle.
- Edge detection:
  - rise = sync & ~prev & RISE_EN; fall = ~sync & prev & FALL_EN.
  - Detection is disarmed until SYNC_STAGES+1 cycles after reset deassertion (arm counter), so no spurious edges are flagged on reset release.
- STATUS update: next = (STATUS & ~w1c_mask) | rise | fall. On a same-cycle set and clear, set wins.
- IRQ: registered; IRQ <= |(STATUS & IRQ_EN). One cycle after STATUS changes.
- Latency (no debounce): a pin toggle is visible in IN after SYNC_STAGES edges; STATUS sets 1 edge later; IRQ follows 1 edge after that.
- OUT/OE writes appear on the pins on the next PCLK edge.
- Reset mid-transfer: all state clears immediately; PRDATA goes to 0 and the in-flight write is lost.

Optional Feature:
GPIO_DEBOUNCE_EN
- Defined:
  - A per-channel counter sits between the sync chain and `sync`.
  - `sync` updates only after the raw synchronised value has differed from `sync` and stayed stable for DEBOUNCE_CYCLES consecutive cycles.
  - Any bounce restarts the count.
  - This adds DEBOUNCE_CYCLES cycles of latency.
  - Counters reset to 0.
- Undefined: no counters; `sync` is the last flop of the chain.

Decomposition:
- Package gpio_pkg:
  - register index localparams (REG_IN..REG_IRQ_EN);
  - register count;
  - function computing the arm-counter width from SYNC_STAGES.
- Sub-module gpio_chan_sync, one instance per channel:
  - sync chain;
  - optional debounce;
  - prev flop;
  - rise/fall pulse outputs.
- The top level holds the APB decode, registers and IRQ.

Test Plan:
- Write OUT=0xA5, OE=0x0F, then read both -> PRDATA 0xA5 / 0x0F; PIN_OUT=0xA5 and PIN_OE=0x0F on the edge after the write; PREADY constantly 1.
- PIN_IN 0x00->0x81 with RISE_EN=0xFF, IRQ_EN=0x01 -> IN reads 0x81 after 2 edges; STATUS=0x81 at edge 3; IRQ=1 at edge 4.
- Write STATUS=0x01 in the same cycle a new rise occurs on bit 0 -> STATUS bit 0 stays 1; writing 0x80 alone -> STATUS=0x01.
- Hold PIN_IN=0xFF through reset release -> STATUS stays 0x00 (arm counter); read of index 7 -> 0.
- Assert PRESET mid-access after OUT=0x3C -> PIN_OUT, STATUS and IRQ are 0 immediately, with no wait for a clock edge.
- GPIO_DEBOUNCE_EN, DEBOUNCE_CYCLES=4: a 3-cycle glitch on bit 2 -> no IN change; a 6-cycle pulse -> IN bit 2 set 4 cycles after sync and STATUS bit 2 set.
